// File: rtl/neureka_streamout_packer_pkg.sv
// Shared types for the streamout packer: latched tile config, status flags and FSM states.
package neureka_streamout_packer_pkg;

    localparam int unsigned PKG_PE_H = 6;
    localparam int unsigned PKG_PE_W = 6;
    localparam int unsigned PKG_DW   = 256;
    localparam int unsigned PKG_AW   = 32;
    localparam int unsigned PKG_HV_W = $clog2(PKG_PE_H + 1);
    localparam int unsigned PKG_WV_W = $clog2(PKG_PE_W + 1);
    localparam int unsigned PKG_KB_W = $clog2(PKG_DW / 8) + 1;

    typedef struct packed {
        logic [PKG_AW-1:0]   base;
        logic [PKG_AW-1:0]   hstride;
        logic [PKG_AW-1:0]   wstride;
        logic [PKG_HV_W-1:0] hvalid;
        logic [PKG_WV_W-1:0] wvalid;
        logic [PKG_KB_W-1:0] kbytes;
    } ctrl_streamout_packer_t;

    typedef struct packed {
        logic busy;
        logic done;
    } flags_streamout_packer_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } packer_state_e;

endpackage

// File: rtl/neureka_packer_fifo.sv
// Two-entry registered FIFO; push and pop in the same cycle are allowed even when full.
module neureka_packer_fifo #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO can only take a word if the head leaves on the same edge.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/neureka_streamout_packer.sv
// Streamout packer: drops out-of-tile PE words, masks strobes to Kout and tags each kept word
// with its TCDM byte address, computed with running row/column pointers.
module neureka_streamout_packer
    import neureka_streamout_packer_pkg::*;
#(
    parameter int unsigned PE_H = 6,
    parameter int unsigned PE_W = 6,
    parameter int unsigned DW   = 256,
    parameter int unsigned AW   = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [AW-1:0]                cfg_base_i,
    input  logic [AW-1:0]                cfg_hstride_i,
    input  logic [AW-1:0]                cfg_wstride_i,
    input  logic [$clog2(PE_H+1)-1:0]    cfg_hvalid_i,
    input  logic [$clog2(PE_W+1)-1:0]    cfg_wvalid_i,
    input  logic [$clog2(DW/8):0]        cfg_kbytes_i,
    input  logic [DW-1:0]                in_data_i,
    input  logic [DW/8-1:0]              in_strb_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic [DW-1:0]                out_data_o,
    output logic [DW/8-1:0]              out_strb_o,
    output logic [AW-1:0]                out_addr_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int unsigned HV_W = $clog2(PE_H + 1);
    localparam int unsigned WV_W = $clog2(PE_W + 1);
    localparam int unsigned KB_W = $clog2(DW / 8) + 1;
    localparam int unsigned SW   = DW / 8;
    localparam int unsigned FW   = DW + SW + AW;

    packer_state_e           state_q, state_d;
    ctrl_streamout_packer_t  cfg_q, cfg_d;
    flags_streamout_packer_t flags;
    logic [HV_W-1:0]         h_q, h_d;
    logic [WV_W-1:0]         w_q, w_d;
    logic [AW-1:0]           row_q, row_d;
    logic [AW-1:0]           col_q, col_d;
    logic                    done_q, done_d;

    logic [HV_W-1:0]         h_lim;
    logic [WV_W-1:0]         w_lim;
    logic [SW-1:0]           strb_mask;
    logic                    keep;
    logic                    w_wrap;
    logic                    last_word;
    logic                    in_ready;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [FW-1:0]           fifo_rdata;

    // Zero in the valid-count fields means the full PE array.
    assign h_lim     = (cfg_q.hvalid == '0) ? HV_W'(PE_H) : cfg_q.hvalid;
    assign w_lim     = (cfg_q.wvalid == '0) ? WV_W'(PE_W) : cfg_q.wvalid;
    assign keep      = (h_q < h_lim) && (w_q < w_lim);
    assign w_wrap    = (w_q == WV_W'(PE_W - 1));
    assign last_word = w_wrap && (h_q == HV_W'(PE_H - 1));

    // Byte-lane mask for the valid Kout channels.
    always_comb begin
        strb_mask = '0;
        for (int i = 0; i < int'(SW); i++) begin
            strb_mask[i] = (cfg_q.kbytes == '0) || (KB_W'(i) < cfg_q.kbytes);
        end
    end

    // Next-state: FSM, config latch, PE counters and address accumulators.
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        h_d       = h_q;
        w_d       = w_q;
        row_d     = row_q;
        col_d     = col_q;
        done_d    = 1'b0;
        in_ready  = 1'b0;
        fifo_push = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d       = StRun;
                    cfg_d.base    = cfg_base_i;
                    cfg_d.hstride = cfg_hstride_i;
                    cfg_d.wstride = cfg_wstride_i;
                    cfg_d.hvalid  = cfg_hvalid_i;
                    cfg_d.wvalid  = cfg_wvalid_i;
                    cfg_d.kbytes  = cfg_kbytes_i;
                    h_d           = '0;
                    w_d           = '0;
                    row_d         = cfg_base_i;
                    col_d         = cfg_base_i;
                end
            end
            StRun: begin
                // Dropped words never wait on the FIFO.
                in_ready = !keep || !fifo_full;
                if (in_valid_i && in_ready) begin
                    fifo_push = keep;
                    if (w_wrap) begin
                        w_d   = '0;
                        h_d   = h_q + HV_W'(1);
                        row_d = row_q + cfg_q.hstride;
                        col_d = row_q + cfg_q.hstride;
                    end else begin
                        w_d   = w_q + WV_W'(1);
                        col_d = col_q + cfg_q.wstride;
                    end
                    if (last_word) begin
                        state_d = StDrain;
                        h_d     = '0;
                    end
                end
            end
            StDrain: begin
                if (fifo_empty) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cfg_q   <= '0;
            h_q     <= '0;
            w_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            h_q     <= h_d;
            w_q     <= w_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= done_d;
        end
    end

    assign fifo_pop = !fifo_empty && out_ready_i;

    neureka_packer_fifo #(
        .WIDTH (FW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({in_data_i, in_strb_i & strb_mask, col_q}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {out_data_o, out_strb_o, out_addr_o} = fifo_rdata;
    assign out_valid_o = !fifo_empty;
    assign in_ready_o  = in_ready;

    assign flags.busy = (state_q != StIdle);
    assign flags.done = done_q;
    assign busy_o     = flags.busy;
    assign done_o     = flags.done;

endmodule
